// File: rtl/digital_clock_pkg.sv
// Shared field widths, limits and mode/selection types for the time-of-day counter.
package digital_clock_pkg;

    localparam int FIELD_W  = 6;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    typedef enum logic {RUN, SET} mode_t;
    typedef enum logic [1:0] {SEL_HOUR, SEL_MINU, SEL_SECO} sel_t;

    function automatic sel_t next_sel(input sel_t cur);
        case (cur)
            SEL_HOUR: return SEL_MINU;
            SEL_MINU: return SEL_SECO;
            default:  return SEL_HOUR;
        endcase
    endfunction

endpackage

// File: rtl/digital_clock_field_cnt.sv
// Wrapping MIN..MAX field counter with a same-cycle carry flag and a registered change strobe.
module clock_field_cnt
    import digital_clock_pkg::*;
#(
    parameter int MAX     = 59,
    parameter int MIN     = 0,
    parameter int RST_VAL = MIN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    output logic [FIELD_W-1:0] value,
    output logic               wrap,
    output logic               changed
);

    logic [FIELD_W-1:0] r_value;
    logic               r_changed;
    logic               w_at_max;

    assign w_at_max = (r_value == FIELD_W'(MAX));
    assign wrap     = inc && w_at_max;

    // The strobe is registered alongside the value so both appear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_value   <= FIELD_W'(RST_VAL);
            r_changed <= 1'b0;
        end else begin
            r_changed <= inc;
            if (inc) begin
                r_value <= w_at_max ? FIELD_W'(MIN) : r_value + FIELD_W'(1);
            end
        end
    end

    assign value   = r_value;
    assign changed = r_changed;

endmodule

// File: rtl/digital_clock.sv
// 24-hour hh:mm:ss counter with a key-driven set mode.
// Defining DIGITAL_CLOCK_12H_EN switches the hour to 1..12 and adds the pm output.
//
//  state | meaning
//  RUN   | prescaler counts, each wrap ticks the seconds
//  SET   | counting frozen, key[1] selects a field, key[0] bumps it
module digital_clock
    import digital_clock_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         key,
    output logic [FIELD_W-1:0] hour,
    output logic [FIELD_W-1:0] minu,
    output logic [FIELD_W-1:0] seco,
    output logic               hour_vld,
    output logic               minu_vld,
    output logic               seco_vld
`ifdef DIGITAL_CLOCK_12H_EN
    ,
    output logic               pm
`endif
);

    localparam int PRESC_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_FREQ - 1);

`ifdef DIGITAL_CLOCK_12H_EN
    localparam int HOUR_LO  = 1;
    localparam int HOUR_HI  = 12;
    localparam int HOUR_RST = 12;
`else
    localparam int HOUR_LO  = 0;
    localparam int HOUR_HI  = HOUR_MAX;
    localparam int HOUR_RST = 0;
`endif

    mode_t              r_mode;
    sel_t               r_sel;
    logic [PRESC_W-1:0] r_presc;

    logic w_key_exit, w_key_enter, w_key_next, w_key_inc;
    logic w_run, w_set, w_tick, w_set_inc;
    logic w_inc_sec, w_inc_min, w_inc_hour;
    logic w_sec_wrap, w_min_wrap, w_unused_hour_wrap;

    // Only the highest-priority key survives decode; mode then decides whether it acts.
    assign w_key_exit  = key[3];
    assign w_key_enter = key[2] & ~key[3];
    assign w_key_next  = key[1] & ~(|key[3:2]);
    assign w_key_inc   = key[0] & ~(|key[3:1]);

    assign w_run     = (r_mode == RUN);
    assign w_set     = (r_mode == SET);
    assign w_tick    = w_run && !w_key_enter && (r_presc == PRESC_LAST);
    assign w_set_inc = w_set && w_key_inc;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_mode  <= RUN;
            r_sel   <= SEL_HOUR;
            r_presc <= '0;
        end else begin
            case (r_mode)
                RUN: begin
                    if (w_key_enter) begin
                        r_mode <= SET;
                        r_sel  <= SEL_HOUR;
                    end else if (w_tick) begin
                        r_presc <= '0;
                    end else begin
                        r_presc <= r_presc + PRESC_W'(1);
                    end
                end
                SET: begin
                    if (w_key_exit) begin
                        r_mode  <= RUN;
                        r_presc <= '0;
                    end else if (w_key_next) begin
                        r_sel <= next_sel(r_sel);
                    end
                end
                default: r_mode <= RUN;
            endcase
        end
    end

    // Carries only propagate on a tick; set-mode bumps wrap within their own field.
    assign w_inc_sec  = w_tick || (w_set_inc && r_sel == SEL_SECO);
    assign w_inc_min  = (w_tick && w_sec_wrap) || (w_set_inc && r_sel == SEL_MINU);
    assign w_inc_hour = (w_tick && w_min_wrap) || (w_set_inc && r_sel == SEL_HOUR);

    clock_field_cnt #(.MAX(SEC_MAX), .MIN(0), .RST_VAL(0)) u_sec (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (w_inc_sec),
        .value   (seco),
        .wrap    (w_sec_wrap),
        .changed (seco_vld)
    );

    clock_field_cnt #(.MAX(MIN_MAX), .MIN(0), .RST_VAL(0)) u_min (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (w_inc_min),
        .value   (minu),
        .wrap    (w_min_wrap),
        .changed (minu_vld)
    );

    clock_field_cnt #(.MAX(HOUR_HI), .MIN(HOUR_LO), .RST_VAL(HOUR_RST)) u_hour (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (w_inc_hour),
        .value   (hour),
        .wrap    (w_unused_hour_wrap),
        .changed (hour_vld)
    );

`ifdef DIGITAL_CLOCK_12H_EN
    logic r_pm;

    // Meridiem flips only when running time crosses 11:59:59 -> 12:00:00.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_pm <= 1'b0;
        end else if (w_tick && w_min_wrap && hour == FIELD_W'(11)) begin
            r_pm <= ~r_pm;
        end
    end

    assign pm = r_pm;
`endif

endmodule

// File: tb/tb_digital_clock.sv
// Self-checking bench for digital_clock (24-hour build, CLK_FREQ=10) against a seconds-of-day model.
module tb_digital_clock;

    localparam int CLK_FREQ = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] key = 4'b0;
    logic [5:0] hour, minu, seco;
    logic       hour_vld, minu_vld, seco_vld;

    int errors = 0;
    int checks = 0;

    // Model: time as seconds of day, mode flag, selected field, cycles since last tick.
    int m_t   = 0;
    bit m_set = 1'b0;
    int m_sel = 0;
    int m_cnt = 0;
    bit e_hv = 1'b0, e_mv = 1'b0, e_sv = 1'b0;

    logic [20:0] dut_vec;
    assign dut_vec = {hour, minu, seco, hour_vld, minu_vld, seco_vld};

    digital_clock #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key      (key),
        .hour     (hour),
        .minu     (minu),
        .seco     (seco),
        .hour_vld (hour_vld),
        .minu_vld (minu_vld),
        .seco_vld (seco_vld)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] exp_vec();
        return {6'(m_t / 3600), 6'((m_t / 60) % 60), 6'(m_t % 60), e_hv, e_mv, e_sv};
    endfunction

    task automatic model_edge(input logic [3:0] k, input logic r);
        int oh, om, os, nh, nm, ns;
        e_hv = 1'b0; e_mv = 1'b0; e_sv = 1'b0;
        if (r) begin
            m_t = 0; m_set = 1'b0; m_sel = 0; m_cnt = 0;
            return;
        end
        oh = m_t / 3600; om = (m_t / 60) % 60; os = m_t % 60;
        nh = oh; nm = om; ns = os;
        if (!m_set) begin
            if (k[2] && !k[3]) begin
                m_set = 1'b1; m_sel = 0;
            end else if (m_cnt == CLK_FREQ - 1) begin
                m_cnt = 0;
                m_t = (m_t + 1) % 86400;
                nh = m_t / 3600; nm = (m_t / 60) % 60; ns = m_t % 60;
            end else begin
                m_cnt++;
            end
        end else if (k[3]) begin
            m_set = 1'b0; m_cnt = 0;
        end else if (k[2]) begin
        end else if (k[1]) begin
            m_sel = (m_sel + 1) % 3;
        end else if (k[0]) begin
            case (m_sel)
                0:       nh = (oh + 1) % 24;
                1:       nm = (om + 1) % 60;
                default: ns = (os + 1) % 60;
            endcase
            m_t = nh * 3600 + nm * 60 + ns;
        end
        e_hv = (nh != oh); e_mv = (nm != om); e_sv = (ns != os);
    endtask

    task automatic step(input logic [3:0] k, input logic r);
        key = k; rst_n = r;
        @(posedge clk);
        model_edge(k, r);
        #1;
        key = 4'b0; rst_n = 1'b0;
    endtask

    task automatic test_reset();
        int first;
        for (int i = 0; i < 3; i++) begin
            step(4'b0, 1'b1);
            if (dut_vec !== 21'd0) begin
                errors++; $display("FAIL reset_state cyc=%0d got=%h exp=%h", i, dut_vec, 21'd0);
            end
            checks++;
        end
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            step(4'b0, 1'b0);
            if (seco_vld === 1'b1 && first < 0) first = i;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL reset_run cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            checks++;
        end
        if (first != CLK_FREQ) begin
            errors++; $display("FAIL first_tick got=%0d exp=%0d", first, CLK_FREQ);
        end
        checks++;
    endtask

    task automatic test_rollover();
        int mv_cnt;
        mv_cnt = 0;
        step(4'b0, 1'b1);
        for (int i = 1; i <= 600 * CLK_FREQ; i++) begin
            step(4'b0, 1'b0);
            if (minu_vld === 1'b1) mv_cnt++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL rollover cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            checks++;
        end
        if ({hour, minu, seco} !== {6'd0, 6'd10, 6'd0}) begin
            errors++; $display("FAIL rollover_end got=%0d:%0d:%0d exp=0:10:0", hour, minu, seco);
        end
        checks++;
        if (mv_cnt != 10) begin
            errors++; $display("FAIL rollover_minu_vld got=%0d exp=10", mv_cnt);
        end
        checks++;
    endtask

    task automatic test_full_wrap();
        step(4'b0, 1'b1);
        step(4'b0100, 1'b0);
        for (int i = 0; i < 23; i++) step(4'b0001, 1'b0);
        step(4'b0010, 1'b0);
        for (int i = 0; i < 59; i++) step(4'b0001, 1'b0);
        step(4'b0010, 1'b0);
        for (int i = 0; i < 59; i++) step(4'b0001, 1'b0);
        if ({hour, minu, seco} !== {6'd23, 6'd59, 6'd59}) begin
            errors++; $display("FAIL wrap_preload got=%0d:%0d:%0d exp=23:59:59", hour, minu, seco);
        end
        checks++;
        step(4'b1000, 1'b0);
        for (int i = 1; i <= CLK_FREQ; i++) begin
            step(4'b0, 1'b0);
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL wrap_run cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            checks++;
        end
        if (dut_vec !== 21'b111) begin
            errors++; $display("FAIL wrap_zero got=%h exp=%h", dut_vec, 21'b111);
        end
        checks++;
    endtask

    task automatic test_set_mode();
        step(4'b0, 1'b1);
        step(4'b0100, 1'b0);
        for (int i = 0; i < 25; i++) begin
            step(4'b0001, 1'b0);
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL set_hour_inc n=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            checks++;
        end
        if (hour !== 6'd1) begin
            errors++; $display("FAIL set_hour_wrap got=%0d exp=1", hour);
        end
        checks++;
        for (int i = 0; i < 3 * CLK_FREQ; i++) step(4'b0, 1'b0);
        if ({seco, seco_vld} !== {6'd0, 1'b0}) begin
            errors++; $display("FAIL set_frozen got=%0d/%0b exp=0/0", seco, seco_vld);
        end
        checks++;
        step(4'b0010, 1'b0);
        for (int i = 0; i < 60; i++) step(4'b0001, 1'b0);
        if ({hour, minu} !== {6'd1, 6'd0}) begin
            errors++; $display("FAIL set_minu_wrap got=%0d:%0d exp=1:0", hour, minu);
        end
        checks++;
    endtask

    task automatic test_exit();
        step(4'b1000, 1'b0);
        for (int i = 1; i <= CLK_FREQ; i++) begin
            step(4'b0, 1'b0);
            if (seco_vld !== (i == CLK_FREQ)) begin
                errors++; $display("FAIL exit_tick cyc=%0d got=%0b exp=%0b", i, seco_vld, i == CLK_FREQ);
            end
            checks++;
        end
        if (seco !== 6'd1) begin
            errors++; $display("FAIL exit_seco got=%0d exp=1", seco);
        end
        checks++;
        step(4'b1100, 1'b0);
        for (int i = 2; i <= CLK_FREQ; i++) step(4'b0, 1'b0);
        if ({seco, seco_vld} !== {6'd2, 1'b1}) begin
            errors++; $display("FAIL run_keys32 got=%0d/%0b exp=2/1", seco, seco_vld);
        end
        checks++;
    endtask

    task automatic test_mid_reset();
        step(4'b0, 1'b1);
        for (int i = 0; i < 37 * CLK_FREQ; i++) step(4'b0, 1'b0);
        if ({hour, minu, seco} !== {6'd0, 6'd0, 6'd37}) begin
            errors++; $display("FAIL midreset_pre got=%0d:%0d:%0d exp=0:0:37", hour, minu, seco);
        end
        checks++;
        step(4'b0, 1'b1);
        if (dut_vec !== 21'd0) begin
            errors++; $display("FAIL midreset_zero got=%h exp=%h", dut_vec, 21'd0);
        end
        checks++;
        for (int i = 1; i <= CLK_FREQ; i++) begin
            step(4'b0, 1'b0);
            if (seco_vld !== (i == CLK_FREQ)) begin
                errors++; $display("FAIL midreset_tick cyc=%0d got=%0b exp=%0b", i, seco_vld, i == CLK_FREQ);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        logic [3:0] k;
        logic       r;
        step(4'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 299) == 0);
            k = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
            step(k, r);
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL random cyc=%0d key=%b got=%h exp=%h", i, k, dut_vec, exp_vec());
            end
            checks++;
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_rollover();
        test_full_wrap();
        test_set_mode();
        test_exit();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
